// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the datapath and a
// word-addressed data memory. Handles byte/halfword/word accesses at byte
// addresses, sign/zero extension on loads, read-modify-write for sub-word
// stores, and rejects misaligned, out-of-range or illegal-size requests
// without touching memory. All outputs are registered.
module mem_access_unit #(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] MemAddr,
  output logic [31:0] MemData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] ReadMemData
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  // Replace the addressed lane of base_word with right-justified store data.
  function automatic logic [31:0] merge_word(input logic [31:0] base_word,
                                             input logic [31:0] store_data,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  lane);
    logic [31:0] m;
    m = base_word;
    case (sz)
      SZ_BYTE: m[{lane, 3'b000} +: 8]      = store_data[7:0];
      SZ_HALF: m[{lane[1], 4'b0000} +: 16] = store_data[15:0];
      SZ_WORD: m = store_data;
      default: m = base_word;
    endcase
    return m;
  endfunction

  // Extract the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane,
                                              input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = {{24{sext & b[7]}}, b};
      SZ_HALF: r = {{16{sext & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = word;
    endcase
    return r;
  endfunction

  logic [1:0]  state_r;
  logic        we_r;
  logic [1:0]  size_r;
  logic        sext_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        err_flag_r;
  logic [31:0] rdata_r;
  logic        done_r;
  logic        err_r;
  logic        busy_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_data_r;
  logic        mem_read_r;
  logic        mem_write_r;

  logic        req_err_s;
  logic [1:0]  state_nx_s;
  logic        done_nx_s;
  logic        err_nx_s;
  logic        mem_read_nx_s;
  logic        mem_write_nx_s;
  logic [31:0] mem_addr_nx_s;
  logic [31:0] mem_data_nx_s;
  logic        latch_s;
  logic        load_rdata_s;

  // Classify the incoming request as illegal before anything is issued.
  always_comb begin
    req_err_s = (size == 2'b11)
              | ((size == SZ_HALF) & addr[0])
              | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
              | ({2'b00, addr[31:2]} >= MEM_WORDS_L);
  end

  // Next-state and next-output decode; outputs are registered so memory
  // strobes are presented for exactly the cycle spent in RD or WR.
  always_comb begin
    state_nx_s     = state_r;
    done_nx_s      = 1'b0;
    err_nx_s       = 1'b0;
    mem_read_nx_s  = 1'b0;
    mem_write_nx_s = 1'b0;
    mem_addr_nx_s  = 32'd0;
    mem_data_nx_s  = 32'd0;
    latch_s        = 1'b0;
    load_rdata_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          latch_s = 1'b1;
          if (req_err_s) begin
            state_nx_s = ST_RESP;
            done_nx_s  = 1'b1;
            err_nx_s   = 1'b1;
          end else if (!we || (size != SZ_WORD)) begin
            // Loads and sub-word stores both need the current word first.
            state_nx_s    = ST_RD;
            mem_read_nx_s = 1'b1;
            mem_addr_nx_s = {2'b00, addr[31:2]};
          end else begin
            state_nx_s     = ST_WR;
            mem_write_nx_s = 1'b1;
            mem_addr_nx_s  = {2'b00, addr[31:2]};
            mem_data_nx_s  = wdata;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (we_r) begin
          // The word read this cycle is the base of the merged store word.
          state_nx_s     = ST_WR;
          mem_write_nx_s = 1'b1;
          mem_addr_nx_s  = {2'b00, addr_r[31:2]};
          mem_data_nx_s  = merge_word(ReadMemData, wdata_r, size_r, addr_r[1:0]);
        end else begin
          state_nx_s   = ST_RESP;
          done_nx_s    = 1'b1;
          load_rdata_s = 1'b1;
        end
      end
      ST_WR: begin
        state_nx_s = ST_RESP;
        done_nx_s  = 1'b1;
        err_nx_s   = err_flag_r;
      end
      ST_RESP: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      size_r      <= 2'b00;
      sext_r      <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      err_flag_r  <= 1'b0;
      rdata_r     <= 32'd0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_data_r  <= 32'd0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      done_r      <= done_nx_s;
      err_r       <= err_nx_s;
      busy_r      <= (state_nx_s != ST_IDLE);
      mem_addr_r  <= mem_addr_nx_s;
      mem_data_r  <= mem_data_nx_s;
      mem_read_r  <= mem_read_nx_s;
      mem_write_r <= mem_write_nx_s;
      if (latch_s) begin
        we_r       <= we;
        size_r     <= size;
        sext_r     <= sign_ext;
        addr_r     <= addr;
        wdata_r    <= wdata;
        err_flag_r <= req_err_s;
      end
      if (load_rdata_s) begin
        rdata_r <= load_extend(ReadMemData, size_r, addr_r[1:0], sext_r);
      end
    end
  end

  assign rdata    = rdata_r;
  assign done     = done_r;
  assign err      = err_r;
  assign busy     = busy_r;
  assign MemAddr  = mem_addr_r;
  assign MemData  = mem_data_r;
  assign MemRead  = mem_read_r;
  assign MemWrite = mem_write_r;

endmodule
